// File: rtl/ext_mem_port_arbiter.sv
`default_nettype none

`ifndef BW_WORD_ADDR
`define BW_WORD_ADDR 24
`endif

// ============================================================================
// Module   : ext_mem_port_arbiter
// Purpose  : Shares the single external-memory (SDRAM) port among N_PORTS
//            processor-side requesters (e.g. I-cache and D-cache). Grants
//            round-robin, holds a grant for one complete transaction (single
//            word or block) and aborts a hung transaction via a watchdog that
//            raises a sticky error flag.
// Ports    : clock_i / reset_i           clock, async active-low reset
//            req_i, reqBlock_i, rw_i,    per-port request fields (one bit per
//            clear_i, add_i, data_i      port; add_i/data_i packed per port)
//            data_o, ready_o, valid_o,   read data broadcast and per-port
//            done_o                      handshake strobes
//            mem_*_o / mem_*_i           single memory-controller port
//            grant_o                     current or last granted port index
//            timeout_o                   sticky watchdog error
// Revision : 1.0 - initial release
// ============================================================================
module ext_mem_port_arbiter #(
    parameter int N_PORTS = 2,
    parameter int ADDR_W  = `BW_WORD_ADDR,
    parameter int TIMEOUT = 4096
) (
    input  logic                        clock_i,
    input  logic                        reset_i,
    input  logic [N_PORTS-1:0]          req_i,
    input  logic [N_PORTS-1:0]          reqBlock_i,
    input  logic [N_PORTS-1:0]          rw_i,
    input  logic [N_PORTS-1:0]          clear_i,
    input  logic [N_PORTS*ADDR_W-1:0]   add_i,
    input  logic [N_PORTS*32-1:0]       data_i,
    output logic [31:0]                 data_o,
    output logic [N_PORTS-1:0]          ready_o,
    output logic [N_PORTS-1:0]          valid_o,
    output logic [N_PORTS-1:0]          done_o,
    output logic                        mem_req_o,
    output logic                        mem_reqBlock_o,
    output logic                        mem_rw_o,
    output logic                        mem_clear_o,
    output logic [ADDR_W-1:0]           mem_add_o,
    output logic [31:0]                 mem_data_o,
    input  logic [31:0]                 mem_data_i,
    input  logic                        mem_ready_i,
    input  logic                        mem_valid_i,
    input  logic                        mem_done_i,
    output logic [$clog2(N_PORTS)-1:0]  grant_o,
    output logic                        timeout_o
);

    localparam int c_GW    = $clog2(N_PORTS);
    localparam int c_CNT_W = $clog2(TIMEOUT);

    localparam logic [c_GW-1:0]    c_PTR_RST  = c_GW'(N_PORTS - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_BUSY  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_GW-1:0]     r_grant;
    logic [c_GW-1:0]     w_grant_nxt;
    logic [c_GW-1:0]     r_ptr;
    logic [c_GW-1:0]     w_ptr_nxt;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_CNT_W-1:0]  w_cnt_nxt;
    logic                r_timeout;
    logic                w_timeout_nxt;
    logic [c_GW-1:0]     w_pick;

    // Unpacked per-port views of the packed address / write-data buses
    logic [ADDR_W-1:0]   w_add_arr  [N_PORTS];
    logic [31:0]         w_data_arr [N_PORTS];

    genvar k;
    generate
        for (k = 0; k < N_PORTS; k++) begin : g_unpack
            assign w_add_arr[k]  = add_i[k*ADDR_W +: ADDR_W];
            assign w_data_arr[k] = data_i[k*32 +: 32];
        end
    endgenerate

    // Round-robin pick: search ptr+1, ptr+2, ... (mod N_PORTS). Scanning the
    // offsets from farthest to nearest lets the nearest requester win by
    // being written last.
    always_comb begin
        logic [c_GW-1:0] w_idx;
        w_pick = r_ptr;
        w_idx  = '0;
        for (int i = N_PORTS; i >= 1; i--) begin
            w_idx = c_GW'((int'(r_ptr) + i) % N_PORTS);
            if (req_i[w_idx]) begin
                w_pick = w_idx;
            end
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state   <= S_IDLE;
            r_grant   <= '0;
            r_ptr     <= c_PTR_RST;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_ptr     <= w_ptr_nxt;
            r_cnt     <= w_cnt_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_grant_nxt    = r_grant;
        w_ptr_nxt      = r_ptr;
        w_cnt_nxt      = r_cnt;
        w_timeout_nxt  = r_timeout;
        mem_req_o      = 1'b0;
        mem_reqBlock_o = 1'b0;
        mem_rw_o       = 1'b0;
        mem_clear_o    = 1'b0;
        mem_add_o      = '0;
        mem_data_o     = '0;
        data_o         = '0;
        ready_o        = '0;
        valid_o        = '0;
        done_o         = '0;

        case (r_state)
            S_IDLE: begin
                if (|req_i) begin
                    w_grant_nxt = w_pick;
                    w_state_nxt = S_ISSUE;
                end
            end

            S_ISSUE: begin
                mem_req_o      = req_i[r_grant];
                mem_reqBlock_o = reqBlock_i[r_grant];
                mem_rw_o       = rw_i[r_grant];
                mem_clear_o    = clear_i[r_grant];
                mem_add_o      = w_add_arr[r_grant];
                mem_data_o     = w_data_arr[r_grant];
                if (!req_i[r_grant]) begin
                    // Withdrawn before acceptance: the pointer is left alone so
                    // this port keeps its place in the rotation.
                    w_state_nxt = S_IDLE;
                end else if (mem_ready_i) begin
                    ready_o[r_grant] = 1'b1;
                    w_cnt_nxt        = '0;
                    w_state_nxt      = S_BUSY;
                end
            end

            S_BUSY: begin
                valid_o[r_grant] = mem_valid_i;
                done_o[r_grant]  = mem_done_i;
                data_o           = mem_data_i;
                if (mem_done_i) begin
                    w_ptr_nxt   = r_grant;
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == c_CNT_LAST) begin
                    // Watchdog abort: the requester still gets its done pulse
                    // so it never waits forever.
                    w_timeout_nxt    = 1'b1;
                    done_o[r_grant]  = 1'b1;
                    w_ptr_nxt        = r_grant;
                    w_state_nxt      = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign grant_o   = r_grant;
    assign timeout_o = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_ext_mem_port_arbiter.sv
`default_nettype none

// ============================================================================
// Module   : tb_ext_mem_port_arbiter
// Purpose  : Self-checking bench for ext_mem_port_arbiter: table-driven
//            vectors, hand-written multi-cycle sequences (withdraw, watchdog,
//            async reset) and randomized traffic against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ext_mem_port_arbiter;

    localparam int N  = 2;
    localparam int AW = 16;
    localparam int TO = 16;
    localparam int GW = $clog2(N);

    logic              clock_i = 1'b0;
    logic              reset_i = 1'b0;
    logic [N-1:0]      req_i, reqBlock_i, rw_i, clear_i;
    logic [N*AW-1:0]   add_i;
    logic [N*32-1:0]   data_i;
    logic [31:0]       data_o;
    logic [N-1:0]      ready_o, valid_o, done_o;
    logic              mem_req_o, mem_reqBlock_o, mem_rw_o, mem_clear_o;
    logic [AW-1:0]     mem_add_o;
    logic [31:0]       mem_data_o, mem_data_i;
    logic              mem_ready_i, mem_valid_i, mem_done_i;
    logic [GW-1:0]     grant_o;
    logic              timeout_o;

    int n_chk  = 0;
    int n_fail = 0;

    ext_mem_port_arbiter #(.N_PORTS(N), .ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clock_i(clock_i), .reset_i(reset_i),
        .req_i(req_i), .reqBlock_i(reqBlock_i), .rw_i(rw_i), .clear_i(clear_i),
        .add_i(add_i), .data_i(data_i),
        .data_o(data_o), .ready_o(ready_o), .valid_o(valid_o), .done_o(done_o),
        .mem_req_o(mem_req_o), .mem_reqBlock_o(mem_reqBlock_o),
        .mem_rw_o(mem_rw_o), .mem_clear_o(mem_clear_o),
        .mem_add_o(mem_add_o), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i),
        .mem_ready_i(mem_ready_i), .mem_valid_i(mem_valid_i), .mem_done_i(mem_done_i),
        .grant_o(grant_o), .timeout_o(timeout_o)
    );

    always #5 clock_i = ~clock_i;

    // ------------------------------------------------------------------
    // Reference model: phase 0 = waiting to arbitrate, 1 = offering the
    // granted request to memory, 2 = transaction in flight. The winner is
    // the requester at the smallest rotational distance after the last
    // port that completed a transaction.
    // ------------------------------------------------------------------
    int            m_phase = 0;
    logic [GW-1:0] m_g     = '0;
    int            m_last  = N - 1;
    int            m_busy  = 0;   // 1-based count of in-flight cycles
    logic          m_to    = 1'b0;

    function automatic int winner(input logic [N-1:0] r, input int last);
        int best;
        int bestd;
        best  = 0;
        bestd = N + 1;
        for (int p = 0; p < N; p++) begin
            int d;
            d = (p - last - 1 + 2 * N) % N;
            if (r[p] && d < bestd) begin
                best  = p;
                bestd = d;
            end
        end
        return best;
    endfunction

    always @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            m_phase <= 0;
            m_g     <= '0;
            m_last  <= N - 1;
            m_busy  <= 0;
            m_to    <= 1'b0;
        end else begin
            case (m_phase)
                0: if (req_i != '0) begin
                    m_g     <= GW'(winner(req_i, m_last));
                    m_phase <= 1;
                end
                1: if (!req_i[m_g]) begin
                    m_phase <= 0;
                end else if (mem_ready_i) begin
                    m_phase <= 2;
                    m_busy  <= 1;
                end
                default: if (mem_done_i || m_busy == TO) begin
                    m_last  <= int'(m_g);
                    m_phase <= 0;
                    if (!mem_done_i) m_to <= 1'b1;
                end else begin
                    m_busy <= m_busy + 1;
                end
            endcase
        end
    end

    logic [N-1:0]  e_ready, e_valid, e_done;
    logic          e_mreq, e_blk, e_rw, e_clr;
    logic [AW-1:0] e_add;
    logic [31:0]   e_wdata, e_data;

    always_comb begin
        e_ready = '0; e_valid = '0; e_done = '0;
        e_mreq = 1'b0; e_blk = 1'b0; e_rw = 1'b0; e_clr = 1'b0;
        e_add = '0; e_wdata = '0; e_data = '0;
        if (reset_i && m_phase == 1) begin
            e_mreq       = req_i[m_g];
            e_blk        = reqBlock_i[m_g];
            e_rw         = rw_i[m_g];
            e_clr        = clear_i[m_g];
            e_add        = add_i[m_g*AW +: AW];
            e_wdata      = data_i[m_g*32 +: 32];
            e_ready[m_g] = req_i[m_g] & mem_ready_i;
        end else if (reset_i && m_phase == 2) begin
            e_valid[m_g] = mem_valid_i;
            e_done[m_g]  = mem_done_i | (m_busy == TO);
            e_data       = mem_data_i;
        end
    end

    // ------------------------------------------------------------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock_i);
        @(negedge clock_i);
    endtask

    task automatic drv(input logic [1:0] req, input logic mrdy, input logic mval, input logic mdone);
        req_i       = req;
        reqBlock_i  = '0;
        mem_ready_i = mrdy;
        mem_valid_i = mval;
        mem_done_i  = mdone;
        mem_data_i  = '0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".ready"}, 64'(ready_o), 64'(e_ready));
        chk({tag, ".valid"}, 64'(valid_o), 64'(e_valid));
        chk({tag, ".done"},  64'(done_o),  64'(e_done));
        chk({tag, ".data"},  64'(data_o),  64'(e_data));
        chk({tag, ".mreq"},  64'(mem_req_o), 64'(e_mreq));
        chk({tag, ".mblk"},  64'(mem_reqBlock_o), 64'(e_blk));
        chk({tag, ".mrw"},   64'(mem_rw_o), 64'(e_rw));
        chk({tag, ".mclr"},  64'(mem_clear_o), 64'(e_clr));
        chk({tag, ".madd"},  64'(mem_add_o), 64'(e_add));
        chk({tag, ".mdata"}, 64'(mem_data_o), 64'(e_wdata));
        chk({tag, ".grant"}, 64'(grant_o), 64'(m_g));
        chk({tag, ".tout"},  64'(timeout_o), 64'(m_to));
    endtask

    // ------------------------------------------------------------------
    typedef struct {
        logic [1:0]  req, blk;
        logic        mrdy, mval, mdone;
        logic [31:0] mdata;
        logic        mreq;
        logic [1:0]  ready, valid, done;
        logic        grant;
        logic [15:0] add;
        logic [31:0] data;
    } vec_t;

    vec_t tv[$];

    task automatic vec(input logic [1:0] req, input logic [1:0] blk,
                       input logic mrdy, input logic mval, input logic mdone,
                       input logic [31:0] mdata, input logic mreq,
                       input logic [1:0] ready, input logic [1:0] valid,
                       input logic [1:0] done, input logic grant,
                       input logic [15:0] add, input logic [31:0] data);
        vec_t v;
        v.req = req; v.blk = blk; v.mrdy = mrdy; v.mval = mval; v.mdone = mdone;
        v.mdata = mdata; v.mreq = mreq; v.ready = ready; v.valid = valid;
        v.done = done; v.grant = grant; v.add = add; v.data = data;
        tv.push_back(v);
    endtask

    initial begin
        // Port 0 single read at 0x10, answered after five in-flight cycles
        vec(2'b01, 2'b00, 0, 0, 0, 32'h0,         0, 2'b00, 2'b00, 2'b00, 0, 16'h0,  32'h0);
        vec(2'b01, 2'b00, 1, 0, 0, 32'h0,         1, 2'b01, 2'b00, 2'b00, 0, 16'h10, 32'h0);
        for (int i = 0; i < 4; i++)
            vec(2'b00, 2'b00, 0, 0, 0, 32'h0,     0, 2'b00, 2'b00, 2'b00, 0, 16'h0,  32'h0);
        vec(2'b00, 2'b00, 0, 1, 1, 32'hCAFE0010,  0, 2'b00, 2'b01, 2'b01, 0, 16'h0,  32'hCAFE0010);
        // Port 1 block read with four data beats while port 0 waits
        vec(2'b10, 2'b00, 0, 0, 0, 32'h0,         0, 2'b00, 2'b00, 2'b00, 0, 16'h0,  32'h0);
        vec(2'b10, 2'b10, 1, 0, 0, 32'h0,         1, 2'b10, 2'b00, 2'b00, 1, 16'h20, 32'h0);
        vec(2'b01, 2'b00, 0, 1, 0, 32'h000000B0,  0, 2'b00, 2'b10, 2'b00, 1, 16'h0,  32'h000000B0);
        vec(2'b01, 2'b00, 0, 0, 0, 32'h0,         0, 2'b00, 2'b00, 2'b00, 1, 16'h0,  32'h0);
        vec(2'b01, 2'b00, 0, 1, 0, 32'h000000B1,  0, 2'b00, 2'b10, 2'b00, 1, 16'h0,  32'h000000B1);
        vec(2'b01, 2'b00, 0, 1, 0, 32'h000000B2,  0, 2'b00, 2'b10, 2'b00, 1, 16'h0,  32'h000000B2);
        vec(2'b01, 2'b00, 0, 1, 0, 32'h000000B3,  0, 2'b00, 2'b10, 2'b00, 1, 16'h0,  32'h000000B3);
        vec(2'b01, 2'b00, 0, 0, 1, 32'h0,         0, 2'b00, 2'b00, 2'b10, 1, 16'h0,  32'h0);
        // Both ports busy: strict alternation with one arbitration cycle
        vec(2'b01, 2'b00, 0, 0, 0, 32'h0,         0, 2'b00, 2'b00, 2'b00, 1, 16'h0,  32'h0);
        vec(2'b01, 2'b00, 1, 0, 0, 32'h0,         1, 2'b01, 2'b00, 2'b00, 0, 16'h10, 32'h0);
        vec(2'b11, 2'b00, 0, 0, 1, 32'h0,         0, 2'b00, 2'b00, 2'b01, 0, 16'h0,  32'h0);
        vec(2'b11, 2'b00, 0, 0, 0, 32'h0,         0, 2'b00, 2'b00, 2'b00, 0, 16'h0,  32'h0);
        vec(2'b11, 2'b00, 1, 0, 0, 32'h0,         1, 2'b10, 2'b00, 2'b00, 1, 16'h20, 32'h0);
        vec(2'b11, 2'b00, 0, 0, 1, 32'h0,         0, 2'b00, 2'b00, 2'b10, 1, 16'h0,  32'h0);
        vec(2'b11, 2'b00, 0, 0, 0, 32'h0,         0, 2'b00, 2'b00, 2'b00, 1, 16'h0,  32'h0);
        vec(2'b11, 2'b00, 1, 0, 0, 32'h0,         1, 2'b01, 2'b00, 2'b00, 0, 16'h10, 32'h0);
        vec(2'b10, 2'b00, 0, 0, 1, 32'h0,         0, 2'b00, 2'b00, 2'b01, 0, 16'h0,  32'h0);

        // Reset state, with requests and memory activity present
        rw_i    = 2'b10;
        clear_i = 2'b00;
        add_i   = {16'h0020, 16'h0010};
        data_i  = {32'h1111_0001, 32'h0000_AAAA};
        drv(2'b11, 1, 1, 1);
        reset_i = 1'b0;
        @(negedge clock_i);
        @(negedge clock_i);
        #1;
        chk("rst.ready", 64'(ready_o), 64'h0);
        chk("rst.valid", 64'(valid_o), 64'h0);
        chk("rst.done",  64'(done_o),  64'h0);
        chk("rst.mreq",  64'(mem_req_o), 64'h0);
        chk("rst.data",  64'(data_o),  64'h0);
        chk("rst.grant", 64'(grant_o), 64'h0);
        chk("rst.tout",  64'(timeout_o), 64'h0);
        drv(2'b00, 0, 0, 0);
        reset_i = 1'b1;
        @(negedge clock_i);

        // Table vectors
        foreach (tv[i]) begin
            req_i       = tv[i].req;
            reqBlock_i  = tv[i].blk;
            mem_ready_i = tv[i].mrdy;
            mem_valid_i = tv[i].mval;
            mem_done_i  = tv[i].mdone;
            mem_data_i  = tv[i].mdata;
            #1;
            chk($sformatf("tv%0d.mreq", i),  64'(mem_req_o), 64'(tv[i].mreq));
            chk($sformatf("tv%0d.ready", i), 64'(ready_o),   64'(tv[i].ready));
            chk($sformatf("tv%0d.valid", i), 64'(valid_o),   64'(tv[i].valid));
            chk($sformatf("tv%0d.done", i),  64'(done_o),    64'(tv[i].done));
            chk($sformatf("tv%0d.grant", i), 64'(grant_o),   64'(tv[i].grant));
            chk($sformatf("tv%0d.add", i),   64'(mem_add_o), 64'(tv[i].add));
            chk($sformatf("tv%0d.data", i),  64'(data_o),    64'(tv[i].data));
            tick();
        end

        // Withdraw: port 1 offered for 10 cycles without acceptance, then drops
        drv(2'b10, 0, 0, 0); #1; tick();
        for (int i = 0; i < 10; i++) begin
            drv(2'b10, 0, 0, 0); #1;
            chk("wd.mreq",  64'(mem_req_o), 64'h1);
            chk("wd.ready", 64'(ready_o),   64'h0);
            chk("wd.grant", 64'(grant_o),   64'h1);
            tick();
        end
        drv(2'b00, 1, 0, 0); #1;
        chk("wd.drop_mreq",  64'(mem_req_o), 64'h0);
        chk("wd.drop_ready", 64'(ready_o),   64'h0);
        tick();
        drv(2'b11, 0, 0, 0); #1;
        chk("wd.idle_mreq", 64'(mem_req_o), 64'h0);
        tick();
        drv(2'b11, 1, 0, 0); #1;
        chk("wd.regrant", 64'(grant_o), 64'h1);
        chk("wd.reready", 64'(ready_o), 64'h2);
        tick();
        drv(2'b00, 0, 0, 1); #1;
        chk("wd.done", 64'(done_o), 64'h2);
        tick();

        // Watchdog: memory never completes
        drv(2'b01, 0, 0, 0); #1; tick();
        drv(2'b01, 1, 0, 0); #1;
        chk("to.ready", 64'(ready_o), 64'h1);
        tick();
        for (int i = 1; i <= TO; i++) begin
            drv(2'b00, 0, 0, 0); #1;
            chk($sformatf("to.done%0d", i), 64'(done_o), (i == TO) ? 64'h1 : 64'h0);
            chk($sformatf("to.flag%0d", i), 64'(timeout_o), 64'h0);
            tick();
        end
        drv(2'b10, 0, 0, 0); #1;
        chk("to.sticky", 64'(timeout_o), 64'h1);
        chk("to.idle_done", 64'(done_o), 64'h0);
        tick();
        drv(2'b10, 1, 0, 0); #1;
        chk("to.next_ready", 64'(ready_o), 64'h2);
        chk("to.sticky2", 64'(timeout_o), 64'h1);
        tick();
        drv(2'b00, 0, 0, 1); #1;
        chk("to.next_done", 64'(done_o), 64'h2);
        tick();

        // Asynchronous reset in the middle of a transaction
        drv(2'b01, 0, 0, 0); #1; tick();
        drv(2'b01, 1, 0, 0); #1; tick();
        drv(2'b00, 0, 1, 0);
        mem_data_i = 32'hDEAD_BEEF;
        #1;
        chk("ar.valid_pre", 64'(valid_o), 64'h1);
        chk("ar.data_pre",  64'(data_o),  64'hDEADBEEF);
        #1;
        reset_i = 1'b0;
        #1;
        chk("ar.valid", 64'(valid_o), 64'h0);
        chk("ar.data",  64'(data_o),  64'h0);
        chk("ar.done",  64'(done_o),  64'h0);
        chk("ar.grant", 64'(grant_o), 64'h0);
        chk("ar.tout",  64'(timeout_o), 64'h0);
        @(negedge clock_i);
        drv(2'b11, 0, 0, 0);
        reset_i = 1'b1;
        #1;
        chk("ar.idle_mreq", 64'(mem_req_o), 64'h0);
        tick();
        drv(2'b11, 1, 0, 0); #1;
        chk("ar.prio_grant", 64'(grant_o), 64'h0);
        chk("ar.prio_ready", 64'(ready_o), 64'h1);
        tick();
        drv(2'b00, 0, 0, 1); #1;
        chk("ar.done2", 64'(done_o), 64'h1);
        tick();

        // Randomized traffic against the reference model
        for (int c = 0; c < 3000; c++) begin
            req_i       = N'($urandom);
            reqBlock_i  = N'($urandom);
            rw_i        = N'($urandom);
            clear_i     = N'($urandom);
            add_i       = (N*AW)'($urandom);
            data_i      = {$urandom, $urandom};
            mem_ready_i = ($urandom % 3) != 0;
            mem_valid_i = 1'($urandom);
            mem_done_i  = ($urandom % 6) == 0;
            mem_data_i  = $urandom;
            #1;
            check_all("rnd");
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
